// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with a small transmit FIFO in front of it.
// Data width, parity, stop bits and the per-bit clock divisor are parameters.
// A valid/ready handshake fills the FIFO. The FSM drains it onto the line,
// and consecutive frames follow each other with no idle gap.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line high; a frame starts as soon as the FIFO holds a word
// S_START | start bit (low) for one bit time
// S_DATA  | DATA_BITS data bits, LSB first
// S_PAR   | parity bit (only reached when PARITY != 0)
// S_STOP  | STOP_BITS stop bits (high); may chain straight into S_START

module uart_tx_param #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_BITS-1:0]                tx_data,
    input  logic                                tx_valid,
    output logic                                tx_ready,
    output logic                                tx,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_BITS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0] BAUD_TC   = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    // Reject unsupported configurations at elaboration time.
    generate
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_div
            $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                 state;
    logic [BW-1:0]          baud;
    logic [NW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shifter;
    logic                   par_bit;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    logic                   push;
    logic                   pop;
    logic                   baud_tc;
    logic [DATA_BITS-1:0]   head;

    assign tx_ready   = (count != FULL);
    assign busy       = (state != S_IDLE) || (count != '0);
    assign fifo_count = count;
    assign head       = mem[rd_ptr];
    assign baud_tc    = (baud == BAUD_TC);
    assign push       = tx_valid && tx_ready;

    // Pop when idle, or on the last cycle of the last stop bit so the next
    // start bit follows with no idle cycle in between.
    always_comb begin
        pop = 1'b0;
        if (count != '0) begin
            if (state == S_IDLE) begin
                pop = 1'b1;
            end else if (state == S_STOP && baud_tc && bit_cnt == STOP_LAST) begin
                pop = 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: registered line output, baud and bit counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_cnt <= '0;
            shifter <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shifter <= head;
                        par_bit <= (^head) ^ (PARITY == 1);
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tc) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= shifter[0];
                        shifter <= shifter >> 1;
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_tc) begin
                        baud <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= S_PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shifter[0];
                            shifter <= shifter >> 1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_PAR: begin
                    if (baud_tc) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_tc) begin
                        baud <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shifter <= head;
                                par_bit <= (^head) ^ (PARITY == 1);
                                tx      <= 1'b0;
                                state   <= S_START;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    baud    <= '0;
                    bit_cnt <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations (8N1, 8E1, 8O1, 7O2, 9N1)
// checked cycle by cycle against a frame-scheduling reference model.

module tb_uart_tx_param;

    localparam int CPB_A[5] = '{4, 4, 4, 4, 2};
    localparam int DB_A[5]  = '{8, 8, 8, 7, 9};
    localparam int PAR_A[5] = '{0, 2, 1, 1, 0};
    localparam int STB_A[5] = '{1, 1, 1, 2, 1};
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] din [5];
    logic [4:0] vld;
    wire  [4:0] txs;
    wire  [4:0] rdys;
    wire  [4:0] bsys;
    wire  [2:0] cnts [5];

    int vectors;
    int miscompares;
    int offer_q[$];

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[0][7:0]), .tx_valid(vld[0]),
        .tx_ready(rdys[0]), .tx(txs[0]), .busy(bsys[0]), .fifo_count(cnts[0]));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[1][7:0]), .tx_valid(vld[1]),
        .tx_ready(rdys[1]), .tx(txs[1]), .busy(bsys[1]), .fifo_count(cnts[1]));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[2][7:0]), .tx_valid(vld[2]),
        .tx_ready(rdys[2]), .tx(txs[2]), .busy(bsys[2]), .fifo_count(cnts[2]));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[3][6:0]), .tx_valid(vld[3]),
        .tx_ready(rdys[3]), .tx(txs[3]), .busy(bsys[3]), .fifo_count(cnts[3]));

    uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_9n1 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[4]), .tx_valid(vld[4]),
        .tx_ready(rdys[4]), .tx(txs[4]), .busy(bsys[4]), .fifo_count(cnts[4]));

    // Frame length in clock cycles for configuration idx.
    function automatic int flen(input int idx);
        return (1 + DB_A[idx] + ((PAR_A[idx] != 0) ? 1 : 0) + STB_A[idx]) * CPB_A[idx];
    endfunction

    // Line level for bit position pos of the frame carrying word w.
    function automatic logic frame_bit(input int idx, input logic [8:0] w, input int pos);
        int db;
        int ones;
        db   = DB_A[idx];
        ones = 0;
        for (int b = 0; b < db; b++) ones += int'(w[b]);
        if (pos == 0) return 1'b0;
        if (pos <= db) return w[pos-1];
        if (PAR_A[idx] != 0 && pos == db + 1)
            return (PAR_A[idx] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    // Runs one stimulus window on instance idx, starting at a falling edge
    // with the DUT idle. Words come from offer_q (one per cycle, -1 = none),
    // then random offers with probability prob% until ncyc. The model places
    // each accepted word's frame at max(accept edge + 1, end of previous frame).
    task automatic run_stream(input int idx, input int ncyc, input int prob, input string name);
        int         l;
        int         prev_end;
        int         limit;
        int         exp_cnt;
        int         word;
        int         st;
        bit         done;
        bit         in_frame;
        logic       exp_tx;
        logic       exp_busy;
        logic       exp_rdy;
        int         acc_e[$];
        int         st_e[$];
        logic [8:0] wq[$];
        l        = flen(idx);
        prev_end = 0;
        done     = 1'b0;
        limit    = ncyc + offer_q.size() + 6 * l + 20;
        for (int t = 0; t < limit; t++) begin
            exp_cnt  = 0;
            in_frame = 1'b0;
            exp_tx   = 1'b1;
            foreach (acc_e[j]) begin
                if (acc_e[j] <= t) exp_cnt++;
                if (st_e[j] <= t) exp_cnt--;
                if (st_e[j] <= t && t < st_e[j] + l) begin
                    in_frame = 1'b1;
                    exp_tx   = frame_bit(idx, wq[j], (t - st_e[j]) / CPB_A[idx]);
                end
            end
            exp_rdy  = (exp_cnt < DEPTH);
            exp_busy = in_frame || (exp_cnt > 0);
            vectors += 4;
            if (txs[idx] !== exp_tx) begin
                miscompares++;
                $display("FAIL %s tx cyc=%0d got=%b want=%b", name, t, txs[idx], exp_tx);
            end
            if (bsys[idx] !== exp_busy) begin
                miscompares++;
                $display("FAIL %s busy cyc=%0d got=%b want=%b", name, t, bsys[idx], exp_busy);
            end
            if (rdys[idx] !== exp_rdy) begin
                miscompares++;
                $display("FAIL %s tx_ready cyc=%0d got=%b want=%b", name, t, rdys[idx], exp_rdy);
            end
            if (cnts[idx] !== 3'(exp_cnt)) begin
                miscompares++;
                $display("FAIL %s fifo_count cyc=%0d got=%0d want=%0d", name, t, cnts[idx], exp_cnt);
            end
            if (t >= ncyc && t >= offer_q.size() && t >= prev_end) begin
                done = 1'b1;
                break;
            end
            word = -1;
            if (t < offer_q.size()) begin
                word = offer_q[t];
            end else if (t < ncyc && $urandom_range(99) < prob) begin
                word = int'($urandom_range((1 << DB_A[idx]) - 1));
            end
            if (word >= 0) begin
                vld[idx] = 1'b1;
                din[idx] = 9'(word);
                if (exp_rdy) begin
                    st = (t + 2 > prev_end) ? t + 2 : prev_end;
                    acc_e.push_back(t + 1);
                    st_e.push_back(st);
                    wq.push_back(9'(word) & 9'((1 << DB_A[idx]) - 1));
                    prev_end = st + l;
                end
            end else begin
                vld[idx] = 1'b0;
                din[idx] = 9'($urandom);
            end
            @(negedge clk);
        end
        vld[idx] = 1'b0;
        if (!done) begin
            miscompares++;
            $display("FAIL %s timeout got=not_idle want=idle_within_%0d_cycles", name, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            vectors += 4;
            if (txs[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset tx inst=%0d got=%b want=1", i, txs[i]);
            end
            if (rdys[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset tx_ready inst=%0d got=%b want=1", i, rdys[i]);
            end
            if (bsys[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset busy inst=%0d got=%b want=0", i, bsys[i]);
            end
            if (cnts[i] !== 3'd0) begin
                miscompares++;
                $display("FAIL reset fifo_count inst=%0d got=%0d want=0", i, cnts[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_frames();
        offer_q = '{9'h0A5};
        run_stream(0, 0, 0, "frame_8n1_a5");
        offer_q = '{9'h007};
        run_stream(1, 0, 0, "frame_8e1_07");
        offer_q = '{9'h007};
        run_stream(2, 0, 0, "frame_8o1_07");
        offer_q = '{9'h055};
        run_stream(3, 0, 0, "frame_7o2_55");
        offer_q = '{9'h1FF};
        run_stream(4, 0, 0, "frame_9n1_1ff");
    endtask

    task automatic test_back_to_back();
        offer_q = '{1, 2, 3, 4, 5, 6};
        run_stream(0, 0, 0, "back_to_back");
    endtask

    task automatic test_push_pop();
        offer_q.delete();
        for (int i = 0; i < 42; i++) offer_q.push_back(-1);
        offer_q[0]  = 9'h011;
        offer_q[1]  = 9'h022;
        offer_q[2]  = 9'h033;
        offer_q[41] = 9'h044;
        run_stream(0, 0, 0, "push_pop");
    endtask

    task automatic test_reset_mid_frame();
        logic exp_bit;
        vld[0] = 1'b1;
        din[0] = 9'h05A;
        @(negedge clk);
        din[0] = 9'h011;
        @(negedge clk);
        din[0] = 9'h022;
        @(negedge clk);
        vld[0] = 1'b0;
        // Frame started at edge 2; move to the middle of the third data bit.
        repeat (2 + 3 * CPB_A[0] + 1 - 3) @(negedge clk);
        exp_bit  = frame_bit(0, 9'h05A, 3);
        vectors += 2;
        if (txs[0] !== exp_bit) begin
            miscompares++;
            $display("FAIL mid_frame tx got=%b want=%b", txs[0], exp_bit);
        end
        if (cnts[0] !== 3'd2) begin
            miscompares++;
            $display("FAIL mid_frame fifo_count got=%0d want=2", cnts[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors += 4;
        if (txs[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid tx got=%b want=1", txs[0]);
        end
        if (cnts[0] !== 3'd0) begin
            miscompares++;
            $display("FAIL rst_mid fifo_count got=%0d want=0", cnts[0]);
        end
        if (rdys[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid tx_ready got=%b want=1", rdys[0]);
        end
        if (bsys[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid busy got=%b want=0", bsys[0]);
        end
        rst_n = 1'b1;
        offer_q = '{9'h03C};
        run_stream(0, 0, 0, "after_reset_3c");
    endtask

    task automatic test_random();
        offer_q.delete();
        run_stream(0, 300, 3, "random_8n1_sparse");
        run_stream(0, 300, 40, "random_8n1_dense");
        run_stream(1, 150, 20, "random_8e1");
        run_stream(2, 150, 20, "random_8o1");
        run_stream(3, 150, 20, "random_7o2");
        run_stream(4, 150, 25, "random_9n1");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        vld         = '0;
        for (int i = 0; i < 5; i++) din[i] = '0;
        test_reset();
        test_frames();
        test_back_to_back();
        test_push_pop();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with a built-in transmit FIFO, valid/ready input handshake, configurable data width, parity and stop bits, and an exact per-bit baud divisor. It replaces the fixed 8N1, button-triggered transmitter in the serial output path. A producer can stream words back-to-back without idle gaps on the line.

## Interface
Parameters:
- CLKS_PER_BIT, 10416: clk cycles per serial bit (≥2).
- DATA_BITS, 8: data bits per frame (5..9).
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: words buffered (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept a word (= !full).
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- fifo_count  out  clog2(FIFO_DEPTH+1)  words currently in the FIFO.

## Operation
- Push: a word is written when tx_valid && tx_ready at a rising edge. A push is impossible when full, because tx_ready=0.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, load the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: LSB first, DATA_BITS bits, each CLKS_PER_BIT cycles. Then go to PAR if PARITY≠0, else STOP.
  - PAR: odd parity makes the total count of ones in data plus parity odd. Even parity makes it even. Lasts one bit time.
  - STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle cycle. Otherwise go to IDLE.
- Baud counter: width clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, and the bit advances at terminal count. There is no off-by-one, so the bit period is exactly CLKS_PER_BIT.
- Bit counter: width clog2(DATA_BITS+1). Cleared on entry to DATA.
- The FIFO read and write pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - A pop never occurs when empty.
- Captured word: tx_data is captured at push. Changes to tx_data after acceptance do not affect the frame.
- Reset (any cycle, including mid-frame):
  - At the next edge: state=IDLE, tx=1, FIFO empty, fifo_count=0, counters=0.
  - tx_ready=1 and busy=0 after that edge.
  - Any partial frame is abandoned. The line simply returns high.
- Illegal parameters (PARITY=3, STOP_BITS∉{1,2}): elaboration error via a generate-time check.

## Timing
- Latency: a word pushed at edge k into an empty FIFO while IDLE is popped at edge k+1. tx goes low from edge k+1.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back frames: the next START begins on the edge right after the final stop-bit cycle.
- tx_ready changes:
  - It falls at the edge where fifo_count becomes FIFO_DEPTH.
  - It rises at the edge of the pop that makes the FIFO non-full.
- busy:
  - It rises at the push edge.
  - It falls at the edge entering IDLE with an empty FIFO.
- All outputs are registered, or derived combinationally only from registers. There is no combinational path from tx_valid to tx_ready.

## Test plan
- 8N1, CLKS_PER_BIT=4: push 0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles (40 cycles total). busy then falls and tx stays 1.
- 8E1: push 0x07 -> parity bit 1. 8O1: push 0x07 -> parity bit 0. 7 data bits, 2 stop bits: push 0x55 -> frame is 44 cycles at CLKS_PER_BIT=4.
- FIFO_DEPTH=4: hold tx_valid with data 0x01..0x06 on consecutive cycles.
  - Expected: 5 words accepted (the first is popped immediately), then tx_ready=0 and fifo_count=4.
  - Five frames then go out back-to-back with no idle gaps, in order 0x01..0x05.
- Simultaneous push and pop: with fifo_count=2, push on the edge that pops at the end of a stop bit -> fifo_count stays 2.
- Reset mid-DATA (third data bit) -> at the next edge tx=1, fifo_count=0, tx_ready=1, busy=0. After release, a new push of 0x3C transmits correctly.
- Width check, DATA_BITS=9, CLKS_PER_BIT=2: push 0x1FF -> nine 1-bits, then stop. Total 22 cycles for 9N1.
